// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word receiver.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

  localparam int unsigned OVS       = 16;
  localparam int unsigned START_MID = 7;
  localparam int unsigned OS_W      = 4;
  localparam int unsigned TO_W      = 8;

endpackage

// File: rtl/uart_word_rx_if.sv
// Byte/word delivery bus between the UART receiver and its consumer.
interface uart_word_rx_if;

  logic        rx;
  logic        clear;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [31:0] word_data;
  logic        word_valid;
  logic        frame_err;
  logic        busy;

  modport master (
    output rx, clear,
    input  byte_data, byte_valid, word_data, word_valid, frame_err, busy
  );

  modport slave (
    input  rx, clear,
    output byte_data, byte_valid, word_data, word_valid, frame_err, busy
  );

endinterface

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, re-phased by restart.
module uart_tick_gen #(
  parameter int unsigned DIV = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_word_rx.sv
// 8N1 UART receiver delivering bytes and little-endian 32-bit words, with
// partial-word flush on framing error, inter-byte timeout or clear.
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int unsigned DIV          = 651,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input logic           clk,
  input logic           reset,
  uart_word_rx_if.slave bus
);

  logic              rx_meta, rx_s, rx_prev;
  uart_rx_state_t    state, state_n;
  logic [OS_W-1:0]   os, os_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [7:0]        shreg, shreg_n;
  logic              tick, restart_c, commit_c, ferr_c;
  logic [1:0]        byte_cnt, lane_c;
  logic [23:0]       word_buf;
  logic [OS_W-1:0]   to_os;
  logic [TO_W-1:0]   to_bits;

  uart_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart_c),
    .tick    (tick)
  );

  // Next-state logic; sampling happens on the oversample tick at each bit midpoint.
  always_comb begin
    state_n   = state;
    os_n      = os;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    restart_c = 1'b0;
    commit_c  = 1'b0;
    ferr_c    = 1'b0;
    lane_c    = bus.clear ? 2'd0 : byte_cnt;
    case (state)
      IDLE: begin
        if (!rx_s && rx_prev) begin
          state_n   = START;
          os_n      = '0;
          restart_c = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (os == OS_W'(START_MID)) begin
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              state_n   = DATA;
              os_n      = '0;
              bit_idx_n = '0;
            end
          end else begin
            os_n = os + OS_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os == OS_W'(OVS - 1)) begin
            os_n    = '0;
            shreg_n = {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) state_n = STOP;
            else                 bit_idx_n = bit_idx + 3'd1;
          end else begin
            os_n = os + OS_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (os == OS_W'(OVS - 1)) begin
            os_n = '0;
            if (rx_s) begin
              commit_c = 1'b1;
              state_n  = IDLE;
            end else begin
              ferr_c  = 1'b1;
              state_n = BREAK;
            end
          end else begin
            os_n = os + OS_W'(1);
          end
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // Synchronizer clears low so a line already idle-high produces no edge.
      rx_meta        <= 1'b0;
      rx_s           <= 1'b0;
      rx_prev        <= 1'b0;
      state          <= IDLE;
      os             <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      byte_cnt       <= '0;
      word_buf       <= '0;
      to_os          <= '0;
      to_bits        <= '0;
      bus.byte_data  <= '0;
      bus.byte_valid <= 1'b0;
      bus.word_data  <= '0;
      bus.word_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      rx_meta        <= bus.rx;
      rx_s           <= rx_meta;
      rx_prev        <= rx_s;
      state          <= state_n;
      os             <= os_n;
      bit_idx        <= bit_idx_n;
      shreg          <= shreg_n;
      bus.byte_valid <= commit_c;
      bus.word_valid <= 1'b0;
      bus.frame_err  <= ferr_c;
      bus.busy       <= (state_n != IDLE);

      // A committed byte wins over clear and then starts a fresh word.
      if (commit_c) begin
        bus.byte_data <= shreg;
        case (lane_c)
          2'd0: word_buf[7:0]   <= shreg;
          2'd1: word_buf[15:8]  <= shreg;
          2'd2: word_buf[23:16] <= shreg;
          default: begin
            bus.word_data  <= {shreg, word_buf};
            bus.word_valid <= 1'b1;
          end
        endcase
        byte_cnt <= lane_c + 2'd1;
      end else if (ferr_c || bus.clear) begin
        byte_cnt <= '0;
      end

      // Inter-byte timeout, measured in bit-times of continuous idle.
      if (state == IDLE && byte_cnt != 2'd0) begin
        if (tick) begin
          if (to_os == OS_W'(OVS - 1)) begin
            to_os <= '0;
            if (to_bits == TO_W'(TIMEOUT_BITS - 1)) begin
              to_bits  <= '0;
              byte_cnt <= '0;
            end else begin
              to_bits <= to_bits + TO_W'(1);
            end
          end else begin
            to_os <= to_os + OS_W'(1);
          end
        end
      end else begin
        to_os   <= '0;
        to_bits <= '0;
      end
    end
  end

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Serial front end that sits directly upstream of the CPU communication controller. It receives 8N1 UART frames on `rx` and runs on the system clock with an internal 16x oversample tick. Each byte it recovers is delivered as a one-cycle pulse, and every four bytes are also assembled into a little-endian 32-bit word for instruction and data loading. Framing errors and inter-byte timeouts flush any partially assembled word, so the controller only ever receives whole words.

## Interface
- `DIV`, 651: clk cycles per oversample tick (100 MHz / (9600 × 16)); legal range 2..65535.
- `TIMEOUT_BITS`, 32: idle bit-times after which a partial word is discarded; legal range 1..255.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low; all state is cleared on a clk edge while low.
- `rx`  in  1  asynchronous serial input, idle high.
- `clear`  in  1  synchronous flush of the partial word; does not abort a byte in flight.
- `byte_data`  out  8  last received byte; holds its value until the next byte.
- `byte_valid`  out  1  one-cycle pulse when `byte_data` updates.
- `word_data`  out  32  last assembled word; holds its value until the next word.
- `word_valid`  out  1  one-cycle pulse when `word_data` updates.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer; all logic uses the synchronized `rx_s`.
- Tick generator: a counter from 0 to DIV-1 emits a one-cycle `tick` on wrap. It restarts from 0 on entry to START, so bit sampling is phase-aligned to the start edge.
- FSM states:
  - IDLE: wait for `rx_s` = 0 (1→0 edge) → START, with oversample count `os` = 0.
  - START: on tick 7, if `rx_s` = 1 it was a glitch → IDLE with no outputs; otherwise `os` = 0 → DATA with `bit_idx` = 0.
  - DATA: every 16 ticks (the bit midpoint), shift `rx_s` into the shift register LSB first. After bit 7 → STOP.
  - STOP: at the midpoint, if `rx_s` = 1, commit the byte and → IDLE.
  - STOP with `rx_s` = 0: pulse `frame_err`, discard the byte, flush the word → BREAK.
  - BREAK: stay until `rx_s` = 1, then → IDLE. This covers break conditions and prevents false starts.
- Word assembly:
  - A 2-bit `byte_cnt` selects the lane; the first byte goes to [7:0] and the fourth to [31:24].
  - When the fourth byte is committed, `word_data` is loaded and `word_valid` pulses in the same cycle as the fourth `byte_valid`. `byte_cnt` wraps to 0.
- Timeout:
  - While `byte_cnt` ≠ 0 and the FSM is in IDLE, count bit-times (16 ticks each).
  - At TIMEOUT_BITS, set `byte_cnt` = 0 and discard the partial lanes. No output pulse is generated.
  - The timeout counter clears on any START.
- `clear` sets `byte_cnt` = 0. If `clear` coincides with a byte commit, the commit wins: the byte is output, and it becomes lane 0 of a fresh word.
- The partial word is never exposed; `word_data` changes only on `word_valid`.

## Timing
- Reset values: `byte_data` = 0x00, `word_data` = 0x0000_0000, `byte_valid`/`word_valid`/`frame_err`/`busy` = 0, state IDLE, `byte_cnt` = 0.
- Latency from the `rx` falling edge to `byte_valid` is 2 clk (sync) + 1 clk (edge detect) + (8 + 16×9) ticks + 1 clk register stage. That is ≈ 9.5 bit-times.
- `busy` rises 3 clk after the `rx` falling edge. It falls in the cycle after `byte_valid`/`frame_err`, or on a glitch abort.
- Back-to-back frames: a start edge arriving in the clk cycle after the STOP→IDLE transition must be accepted. Stop-bit duration beyond its midpoint is not required.
- Reset asserted mid-frame: all state clears on the next clk edge, with no pulses. After reset is released, a line held low is ignored until it returns high, because IDLE requires an edge.
- There is no backpressure: the consumer must accept the pulses in the cycle they occur.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t`
  - `localparam OVS = 16`
  - `localparam START_MID = 7`
- Sub-module `uart_tick_gen` (parameter DIV; inputs `clk`, `reset`, `restart`; output `tick`).
- Everything else (synchronizer, FSM, assembler, timeout) stays in `uart_word_rx`.

## Test plan
All scenarios use DIV = 4.
- Send 0x55, then 0xA3, with 1 stop bit each → `byte_valid` pulses twice with 0x55 and 0xA3; `word_valid` stays 0; no `frame_err`.
- Send 0x78, 0x56, 0x34, 0x12 back-to-back → a single `word_valid` with `word_data` = 0x1234_5678, coincident with the fourth `byte_valid`.
- Send a 3-tick low pulse on idle `rx` → no pulses; `busy` returns to 0 after the tick-7 check.
- Send 0x11, then a frame with stop bit = 0, then 0xAA, 0xBB, 0xCC, 0xDD → `frame_err` pulses once; the word is 0xDDCC_BBAA.
- Send 0x01, 0x02, idle for TIMEOUT_BITS + 1 bit-times, then 4 bytes 0x04, 0x03, 0x02, 0x01 → the word is 0x0102_0304. Repeat with `clear` asserted instead of idling → same word.
- Assert reset during DATA bit 4 of a frame → all outputs are 0 next cycle; the next full frame 0x3C is received correctly.
